revers_cnt_bcd_ndigit: RTL and testbench

Parametrised multi-digit reversible BCD counter with a programmable upper bound. It supports synchronous parallel load, enable, wrap or saturate mode, a registered carry/borrow pulse, and load-error flagging. It generalises the single-digit reversible BCD counter and serves as the building block for clocks, timers and decimal displays. Cascading is done through `co`.

---
 rtl/bcd_pkg.sv | 41 ++++
 rtl/bcd_digit.sv | 36 +++
 rtl/revers_cnt_bcd_ndigit.sv | 106 ++++++++++
 tb/tb_revers_cnt_bcd_ndigit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the reversible multi-digit counter.
package bcd_pkg;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] DIGIT_MIN  = 4'd0;

    localparam logic       UP         = 1'b0;
    localparam logic       DOWN       = 1'b1;

    // Helpers operate on a 32-bit carrier so one function serves every DIGITS.
    localparam int         MAX_DIGITS = 8;

    // True when the low 'digits' nibbles of v are all in 0..9.
    function automatic logic is_bcd(input logic [31:0] v, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] > DIGIT_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // a <= b, comparing digit by digit from the most significant one.
    function automatic logic bcd_le(input logic [31:0] a, input logic [31:0] b,
                                    input int digits);
        logic le;
        logic decided;
        le      = 1'b1;
        decided = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits && !decided && a[4*i +: 4] != b[4*i +: 4]) begin
                le      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return le;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD nibble cell: increments or decrements when its carry/borrow input
// is set, and reports rollover to the next more significant digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       i_cin,
    input  logic       i_dir,
    input  logic [3:0] i_val,
    output logic [3:0] o_next,
    output logic       o_cout
);

    // Single-digit step with 9->0 carry (up) and 0->9 borrow (down).
    always_comb begin
        o_next = i_val;
        o_cout = 1'b0;
        if (i_cin) begin
            if (i_dir == UP) begin
                if (i_val >= DIGIT_MAX) begin
                    o_next = DIGIT_MIN;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_val + 4'd1;
                end
            end else begin
                if (i_val == DIGIT_MIN) begin
                    o_next = DIGIT_MAX;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_val - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/revers_cnt_bcd_ndigit.sv
// Multi-digit reversible BCD counter with programmable upper bound, parallel
// load with validation, wrap/saturate mode, carry/borrow pulse and sticky
// load-error flag. Priority at every edge: res > load > en.
module revers_cnt_bcd_ndigit
    import bcd_pkg::*;
#(
    parameter int                  DIGITS   = 4,
    parameter logic [4*DIGITS-1:0] MAX_BCD  = {DIGITS{4'h9}},
    parameter bit                  SATURATE = 1'b0
)(
    input  logic                clk,
    input  logic                res,
    input  logic                en,
    input  logic                revers,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    output logic [4*DIGITS-1:0] Q,
    output logic                co,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    // Reject illegal configurations at elaboration.
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("revers_cnt_bcd_ndigit: DIGITS must be 1..8");
    end
    if (!is_bcd(32'(MAX_BCD), DIGITS)) begin : g_bad_max
        $error("revers_cnt_bcd_ndigit: MAX_BCD is not a valid BCD value");
    end

    logic [W-1:0]    r_q;
    logic            r_co;
    logic            r_err;

    logic [DIGITS:0] w_chain;
    logic [W-1:0]    w_step;
    logic            w_at_bound;
    logic            w_load_ok;
    logic [W-1:0]    w_q_nxt;
    logic            w_co_nxt;
    logic            w_err_nxt;

    // The least significant digit always steps; higher digits step on ripple.
    assign w_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_cin  (w_chain[g]),
            .i_dir  (revers),
            .i_val  (r_q[4*g +: 4]),
            .o_next (w_step[4*g +: 4]),
            .o_cout (w_chain[g+1])
        );
    end

    // Counting down, a borrow out of the top digit means every digit was 0.
    // Counting up, the bound is MAX_BCD rather than all nines.
    assign w_at_bound = (revers == DOWN) ? w_chain[DIGITS] : (r_q == MAX_BCD);

    assign w_load_ok  = is_bcd(32'(data), DIGITS) &&
                        bcd_le(32'(data), 32'(MAX_BCD), DIGITS);

    // Load/count priority mux. co is a one-cycle pulse, so it drops whenever
    // no bound event happens, including idle cycles.
    always_comb begin
        w_q_nxt   = r_q;
        w_co_nxt  = 1'b0;
        w_err_nxt = r_err;
        if (load) begin
            if (w_load_ok) begin
                w_q_nxt   = data;
                w_err_nxt = 1'b0;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (w_at_bound) begin
                w_co_nxt = 1'b1;
                if (!SATURATE) begin
                    w_q_nxt = (revers == DOWN) ? MAX_BCD : '0;
                end
            end else begin
                w_q_nxt = w_step;
            end
        end
    end

    // State registers with synchronous reset taking precedence over all else.
    always_ff @(posedge clk) begin
        if (res) begin
            r_q   <= '0;
            r_co  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_co  <= w_co_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign Q   = r_q;
    assign co  = r_co;
    assign err = r_err;

endmodule

// File: tb/tb_revers_cnt_bcd_ndigit.sv
// Bench for the reversible BCD counter: instance A wraps at 59, instance B
// saturates at 99. A decimal reference model predicts {Q, co, err}.
module tb_revers_cnt_bcd_ndigit;

    logic       clk;
    logic       a_res, a_en, a_revers, a_load;
    logic [7:0] a_data, a_q;
    logic       a_co, a_err;
    logic       b_res, b_en, b_revers, b_load;
    logic [7:0] b_data, b_q;
    logic       b_co, b_err;

    logic [9:0] exp_q[$];
    int         n_run;
    int         n_fail;

    // Reference model state (decimal values).
    int         ma_q, mb_q;
    bit         ma_err, mb_err;

    revers_cnt_bcd_ndigit #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b0)) u_dut_a (
        .clk(clk), .res(a_res), .en(a_en), .revers(a_revers), .load(a_load),
        .data(a_data), .Q(a_q), .co(a_co), .err(a_err)
    );

    revers_cnt_bcd_ndigit #(.DIGITS(2), .MAX_BCD(8'h99), .SATURATE(1'b1)) u_dut_b (
        .clk(clk), .res(b_res), .en(b_en), .revers(b_revers), .load(b_load),
        .data(b_data), .Q(b_q), .co(b_co), .err(b_err)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Decimal reference for one clock edge.
    task automatic model_step(input int max, input bit sat,
                              input logic r, input logic l, input logic e,
                              input logic rv, input logic [7:0] d,
                              inout int q, inout bit er, output bit c);
        c = 1'b0;
        if (r) begin
            q  = 0;
            er = 1'b0;
        end else if (l) begin
            if (d[7:4] <= 4'd9 && d[3:0] <= 4'd9 && bcd2int(d) <= max) begin
                q  = bcd2int(d);
                er = 1'b0;
            end else begin
                er = 1'b1;
            end
        end else if (e) begin
            if (!rv) begin
                if (q == max) begin
                    c = 1'b1;
                    if (!sat) q = 0;
                end else begin
                    q = q + 1;
                end
            end else begin
                if (q == 0) begin
                    c = 1'b1;
                    if (!sat) q = max;
                end else begin
                    q = q - 1;
                end
            end
        end
    endtask

    // Driver: sel=0 drives A, sel=1 drives B; pushes the predicted outputs
    // and returns just after the edge that produces them.
    task automatic drive(input bit sel, input logic r, input logic l,
                         input logic e, input logic rv, input logic [7:0] d);
        bit c;
        @(negedge clk);
        if (!sel) begin
            a_res = r; a_load = l; a_en = e; a_revers = rv; a_data = d;
            model_step(59, 1'b0, r, l, e, rv, d, ma_q, ma_err, c);
            exp_q.push_back({int2bcd(ma_q), c, ma_err});
        end else begin
            b_res = r; b_load = l; b_en = e; b_revers = rv; b_data = d;
            model_step(99, 1'b1, r, l, e, rv, d, mb_q, mb_err, c);
            exp_q.push_back({int2bcd(mb_q), c, mb_err});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] exp;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        exp = exp_q.pop_front();
        n_run++;
        if ({a_q, a_co, a_err} !== exp) begin
            n_fail++;
            $display("FAIL reset_a: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                     a_q, a_co, a_err, exp[9:2], exp[1], exp[0]);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        exp = exp_q.pop_front();
        n_run++;
        if ({b_q, b_co, b_err} !== exp) begin
            n_fail++;
            $display("FAIL reset_b: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                     b_q, b_co, b_err, exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic test_count_up;
        logic [9:0] exp;
        int         pulses;
        pulses = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        void'(exp_q.pop_front());
        for (int i = 0; i < 61; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL count_up step %0d: got q=%h co=%b want q=%h co=%b",
                         i, a_q, a_co, exp[9:2], exp[1]);
            end
            if (a_co === 1'b1) pulses++;
        end
        n_run++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL count_up_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_count_down;
        logic [9:0] exp;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        void'(exp_q.pop_front());
        for (int i = 0; i < 52; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL count_down step %0d: got q=%h co=%b want q=%h co=%b",
                         i, a_q, a_co, exp[9:2], exp[1]);
            end
        end
    endtask

    task automatic test_load;
        logic [7:0] vals[5];
        logic [9:0] exp;
        vals = '{8'h5A, 8'h62, 8'h37, 8'hA3, 8'h59};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vals[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL load %h: got q=%h err=%b want q=%h err=%b",
                         vals[i], a_q, a_err, exp[9:2], exp[0]);
            end
            // Counting keeps going after each load, error flag or not.
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL load_then_count %0d: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                         i, a_q, a_co, a_err, exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_saturate;
        logic [9:0] exp;
        // load 98, then up x3, reset, then down x2, then idle
        logic       l_v[7];
        logic       r_v[7];
        logic       e_v[7];
        logic       rv_v[7];
        l_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        r_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        rv_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, r_v[i], l_v[i], e_v[i], rv_v[i], 8'h98);
            exp = exp_q.pop_front();
            n_run++;
            if ({b_q, b_co, b_err} !== exp) begin
                n_fail++;
                $display("FAIL saturate step %0d: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                         i, b_q, b_co, b_err, exp[9:2], exp[1], exp[0]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        exp = exp_q.pop_front();
        n_run++;
        if ({b_q, b_co, b_err} !== exp) begin
            n_fail++;
            $display("FAIL saturate_idle: got q=%h co=%b want q=%h co=%b",
                     b_q, b_co, exp[9:2], exp[1]);
        end
    endtask

    task automatic test_simultaneous;
        logic [9:0] exp;
        // load+en, load 46, en (->47), then res+en mid-count
        logic       r_v[4];
        logic       l_v[4];
        logic [7:0] d_v[4];
        r_v = '{1'b0, 1'b0, 1'b0, 1'b1};
        l_v = '{1'b1, 1'b1, 1'b0, 1'b0};
        d_v = '{8'h12, 8'h46, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, r_v[i], l_v[i], 1'b1, 1'b0, d_v[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL simultaneous step %0d: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                         i, a_q, a_co, a_err, exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_direction_flip;
        logic [9:0] exp;
        // up x5 to 05, idle edge with revers toggled, then down x2
        logic       e_v[8];
        logic       rv_v[8];
        e_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        rv_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, e_v[i], rv_v[i], 8'h00);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL direction_flip step %0d: got q=%h co=%b want q=%h co=%b",
                         i, a_q, a_co, exp[9:2], exp[1]);
            end
        end
    endtask

    task automatic test_random;
        logic [9:0] exp;
        logic       r, l, e, rv;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            rv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) d = int2bcd(int'($urandom_range(0, 69)));
            else                           d = 8'($urandom_range(0, 255));
            drive(1'b0, r, l, e, rv, d);
            exp = exp_q.pop_front();
            n_run++;
            if ({a_q, a_co, a_err} !== exp) begin
                n_fail++;
                $display("FAIL random step %0d: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                         i, a_q, a_co, a_err, exp[9:2], exp[1], exp[0]);
            end
        end
        for (int i = 0; i < 150; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            rv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) d = int2bcd(int'($urandom_range(90, 99)));
            else                           d = 8'($urandom_range(0, 255));
            drive(1'b1, r, l, e, rv, d);
            exp = exp_q.pop_front();
            n_run++;
            if ({b_q, b_co, b_err} !== exp) begin
                n_fail++;
                $display("FAIL random_sat step %0d: got q=%h co=%b err=%b want q=%h co=%b err=%b",
                         i, b_q, b_co, b_err, exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    // Sequencer and final report.
    initial begin
        n_run  = 0;
        n_fail = 0;
        ma_q = 0; ma_err = 1'b0;
        mb_q = 0; mb_err = 1'b0;
        a_res = 1'b0; a_en = 1'b0; a_revers = 1'b0; a_load = 1'b0; a_data = 8'h00;
        b_res = 1'b0; b_en = 1'b0; b_revers = 1'b0; b_load = 1'b0; b_data = 8'h00;

        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_saturate();
        test_simultaneous();
        test_direction_flip();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
